// File: rtl/ovc_allocator.sv
//-----------------------------------------------------------------------------
// ovc_allocator
//
// Output-VC allocator for one router output port. It watches head-flit
// requests from NINPUTS input VCs and hands a free output VC to one of them.
// A grant lasts exactly one cycle, so at most one grant is issued every two
// cycles. Each output VC stays owned (busy) until its tail flit leaves,
// which is signalled by a one-cycle pulse on ovc_release.
//
// Parameters
//   VC_WIDTH  width of an output VC index
//   NINPUTS   number of input VCs arbitrated
//   NOVCS     number of output VCs managed (1 <= NOVCS <= 2**VC_WIDTH)
//
// Ports
//   clock            rising-edge clock
//   reset            asynchronous, active-low reset
//   ivc_req          per-input-VC head-flit request
//   ovc_release      per-output-VC release pulse (tail flit departed)
//   allocate_enable  grant valid, high for the single GRANT cycle
//   ivc_sel          one-hot granted input VC, zero outside GRANT
//   allocated_vc     granted output VC index, zero outside GRANT
//   ovc_busy         per-output-VC ownership status
//
// Configuration
//   OVC_ALLOC_FIXED_PRIORITY_EN  when defined, the lowest-index requesting
//                                input VC always wins and no round-robin
//                                pointer exists. When undefined, the search
//                                starts at a rotating pointer that moves to
//                                one past the last winner.
//-----------------------------------------------------------------------------
module ovc_allocator #(
   parameter int VC_WIDTH = 1,
   parameter int NINPUTS  = 10,
   parameter int NOVCS    = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NINPUTS-1:0]  ivc_req,
   input  logic [NOVCS-1:0]    ovc_release,
   output logic                allocate_enable,
   output logic [NINPUTS-1:0]  ivc_sel,
   output logic [VC_WIDTH-1:0] allocated_vc,
   output logic [NOVCS-1:0]    ovc_busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t state;

   // Low for the first edge after reset so that the earliest grant is taken
   // on the second rising edge following reset release.
   logic armed;

   // Request vector seen by the priority search, already rotated so that
   // bit 0 corresponds to the input VC with the highest priority this cycle,
   // plus the index of that highest-priority input VC.
   logic [NINPUTS-1:0] req_rot;
   int                 base;

`ifdef OVC_ALLOC_FIXED_PRIORITY_EN
   assign req_rot = ivc_req;
   assign base    = 0;
`else
   localparam int PTR_W = (NINPUTS > 1) ? $clog2(NINPUTS) : 1;

   logic [PTR_W-1:0]     ptr;
   logic [PTR_W-1:0]     ptr_after;
   logic [2*NINPUTS-1:0] req_dbl;

   // Doubling the vector and shifting right by ptr gives a circular rotate.
   assign req_dbl = {ivc_req, ivc_req} >> ptr;
   assign req_rot = req_dbl[NINPUTS-1:0];
   assign base    = int'(ptr);
`endif

   //----------------------------------------------------------------------
   // Input VC arbitration: first set bit of the rotated vector, mapped back
   // to the absolute input VC index.
   //----------------------------------------------------------------------
   logic               req_found;
   int                 win_k;
   logic [NINPUTS-1:0] sel_next;

   always_comb begin : arbitrate
      req_found = 1'b0;
      win_k     = 0;
      sel_next  = '0;
      for (int j = 0; j < NINPUTS; j++) begin
         if (!req_found && req_rot[j]) begin
            req_found = 1'b1;
            win_k     = base + j;
            if (win_k >= NINPUTS) begin
               win_k = win_k - NINPUTS;
            end
         end
      end
      for (int i = 0; i < NINPUTS; i++) begin
         if (req_found && (i == win_k)) begin
            sel_next[i] = 1'b1;
         end
      end
   end

`ifndef OVC_ALLOC_FIXED_PRIORITY_EN
   // Pointer moves to one past the winner, wrapping at NINPUTS.
   assign ptr_after = ((win_k + 1) >= NINPUTS) ? '0 : PTR_W'(win_k + 1);
`endif

   //----------------------------------------------------------------------
   // Output VC choice: lowest index whose registered busy bit is clear.
   // A release only clears the busy bit at the next edge, so a VC released
   // this cycle is still seen as busy here and becomes eligible next cycle.
   //----------------------------------------------------------------------
   logic                vc_found;
   logic [VC_WIDTH-1:0] vc_next;
   logic [NOVCS-1:0]    vc_mask;

   always_comb begin : pick_vc
      vc_found = 1'b0;
      vc_next  = '0;
      vc_mask  = '0;
      for (int v = 0; v < NOVCS; v++) begin
         if (!vc_found && !ovc_busy[v]) begin
            vc_found   = 1'b1;
            vc_next    = VC_WIDTH'(v);
            vc_mask[v] = 1'b1;
         end
      end
   end

   // Requests are only looked at in IDLE, so a requester still holding its
   // request while it sees its grant is not granted a second time.
   logic grant_now;
   assign grant_now = (state == IDLE) && armed && req_found && vc_found;

   //----------------------------------------------------------------------
   // FSM with registered outputs and output-VC ownership.
   //----------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         armed           <= 1'b0;
         ovc_busy        <= '0;
         allocate_enable <= 1'b0;
         ivc_sel         <= '0;
         allocated_vc    <= '0;
`ifndef OVC_ALLOC_FIXED_PRIORITY_EN
         ptr             <= '0;
`endif
      end else begin
         armed <= 1'b1;

         // Releasing a VC that is not busy has no effect. A VC being granted
         // is free, so a same-cycle release of it cannot cancel the grant.
         ovc_busy <= (ovc_busy & ~ovc_release) | (grant_now ? vc_mask : '0);

         case (state)
            IDLE: begin
               if (grant_now) begin
                  state           <= GRANT;
                  allocate_enable <= 1'b1;
                  ivc_sel         <= sel_next;
                  allocated_vc    <= vc_next;
`ifndef OVC_ALLOC_FIXED_PRIORITY_EN
                  ptr             <= ptr_after;
`endif
               end
            end
            GRANT: begin
               state           <= IDLE;
               allocate_enable <= 1'b0;
               ivc_sel         <= '0;
               allocated_vc    <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/ovc_allocator.md
OVC_ALLOCATOR -- requirements
Module: ovc_allocator

Interface
REQ-001 SHALL have parameter VC_WIDTH, default 1: width of an output VC index.
REQ-002 SHALL have parameter NINPUTS, default 10: number of input VCs arbitrated.
REQ-003 SHALL have parameter NOVCS, default 2: number of output VCs managed, with 1 <= NOVCS <= 2**VC_WIDTH.
REQ-004 SHALL have port clock, input, 1: single clock, rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port ivc_req, input, NINPUTS: per-input-VC head-flit request for an output VC.
REQ-007 SHALL have port ovc_release, input, NOVCS: per-output-VC release pulse, asserted when a tail flit departs.
REQ-008 SHALL have port allocate_enable, output, 1: grant valid.
REQ-009 SHALL have port ivc_sel, output, NINPUTS: one-hot granted input VC.
REQ-010 SHALL have port allocated_vc, output, VC_WIDTH: output VC index granted.
REQ-011 SHALL have port ovc_busy, output, NOVCS: per-output-VC ownership status.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-013 In IDLE, with at least one ivc_req bit set and at least one ovc_busy bit clear, the FSM SHALL move to GRANT on the next edge; otherwise it SHALL stay in IDLE.
REQ-014 In GRANT, the FSM SHALL return to IDLE unconditionally on the next edge, so that grants occur at most once every 2 cycles.
REQ-015 allocate_enable SHALL be registered and high exactly during the GRANT state, with a latency of 1 cycle from the sampled request.
REQ-016 ivc_sel and allocated_vc SHALL be registered, stable throughout GRANT, and all-zero in IDLE.
REQ-017 The winning input VC SHALL be the first set ivc_req bit, searching circularly upward from the round-robin pointer ptr (range 0..NINPUTS-1).
REQ-018 On a grant to input VC k, ptr SHALL become (k+1) mod NINPUTS, wrapping from NINPUTS-1 to 0.
REQ-019 When no grant is issued, ptr SHALL remain unchanged.
REQ-020 The granted output VC SHALL be the lowest-index output VC whose ovc_busy bit is clear in the sampling cycle.
REQ-021 ovc_busy[v] SHALL be set on the edge that enters GRANT with allocated_vc = v.
REQ-022 ovc_busy[v] SHALL be cleared on the edge following an ovc_release[v] pulse.
REQ-023 An ovc_release bit for an output VC that is not busy SHALL be ignored.
REQ-024 An output VC released in cycle t SHALL NOT be granted in cycle t; it SHALL be eligible from cycle t+1.
REQ-025 Requests SHALL be ignored during GRANT, so a requester that still holds ivc_req while seeing its grant is not granted twice.
REQ-026 When all NOVCS output VCs are busy, no grant SHALL be issued and outstanding requests SHALL wait with no loss of state.
REQ-027 ivc_sel SHALL always be either all-zero or exactly one-hot.

Reset
REQ-028 Asserting reset low SHALL immediately clear the FSM to IDLE, ptr to 0, ovc_busy to all-zero, and allocate_enable, ivc_sel and allocated_vc to 0, regardless of the clock.
REQ-029 A reset asserted during GRANT SHALL abort the grant with no output VC left busy.
REQ-030 After reset deasserts, the first grant SHALL be possible on the second rising edge.

Configuration
REQ-031 The macro OVC_ALLOC_FIXED_PRIORITY_EN SHALL select the arbitration policy.
REQ-032 With OVC_ALLOC_FIXED_PRIORITY_EN defined, the lowest-index requesting input VC SHALL always win and the ptr register SHALL be absent.
REQ-033 With OVC_ALLOC_FIXED_PRIORITY_EN undefined, round-robin arbitration per REQ-017 to REQ-019 SHALL apply.

Verification (NINPUTS=10, VC_WIDTH=1, NOVCS=2, round-robin unless stated)
REQ-034 After reset: ivc_req=0x001 -> one cycle later allocate_enable=1, ivc_sel=0x001, allocated_vc=0; next cycle ovc_busy=01 and outputs are 0.
REQ-035 Round-robin: ivc_req=0x201 held, with releases issued between grants -> grants go to 0x001, 0x200, 0x001 (pointer wraps 9 to 0).
REQ-036 Exhaustion: both output VCs busy with ivc_req=0x004 -> allocate_enable stays 0; pulse ovc_release=10 -> grant of ivc_sel=0x004, allocated_vc=1 two cycles after the pulse.
REQ-037 Release of a free VC: ovc_busy=01, ovc_release=10 -> ovc_busy stays 01 with no other effect.
REQ-038 Mid-GRANT reset: assert reset low during GRANT -> all outputs and ovc_busy read 0 immediately, before the next edge.
REQ-039 Fixed priority: with OVC_ALLOC_FIXED_PRIORITY_EN defined and ivc_req=0x201 held, releasing after each grant -> every grant selects ivc_sel=0x001.
